// File: rtl/unified_mem_arbiter.sv
// ---------------------------------------------------------------------------
// unified_mem_arbiter
//
// Shares one single-port unified RAM between the IF stage (instruction fetch)
// and the MEM stage (load/store from the EX/MEM register). Each access holds
// the RAM interface stable for MEM_LATENCY cycles, latches the read data on
// the last cycle, and marks the requester as served. pipe_stall stays high
// while any active requester has not yet been served in the current pipeline
// cycle. MEM has priority over IF because it is the older instruction.
//
// Parameters:
//   MEM_LATENCY  RAM cycles per access (1..15)
//   ADDR_W       address width
//   DATA_W       data width
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   if_req, if_addr          instruction fetch request / PC
//   if_rdata                 fetched instruction (valid once IF is served)
//   mem_req, mem_we          data request, 1=store 0=load
//   mem_addr, mem_wdata      data address / store data
//   mem_rdata                load data (valid once MEM is served)
//   pipe_stall               freeze all pipeline registers and PC
//   ram_en, ram_we           RAM access / write enable (registered)
//   ram_addr, ram_wdata      RAM address / write data (registered)
//   ram_rdata                RAM read data, valid on last access cycle
//   stall_cycles             (ARB_PERF_CNT_EN only) saturating count of
//                            clock edges seen with pipe_stall=1
//
// Optional feature macro: ARB_PERF_CNT_EN
// ---------------------------------------------------------------------------
module unified_mem_arbiter #(
    parameter int unsigned MEM_LATENCY = 2,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              pipe_stall,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_MEM = 2'd1,
        BUSY_IF  = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    state_t              state_q,      state_d;
    logic [3:0]          cnt_q,        cnt_d;
    logic                if_served_q,  if_served_d;
    logic                mem_served_q, mem_served_d;
    logic [DATA_W-1:0]   if_rdata_q,   if_rdata_d;
    logic [DATA_W-1:0]   mem_rdata_q,  mem_rdata_d;
    logic                ram_en_q,     ram_en_d;
    logic                ram_we_q,     ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q,   ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q,  ram_wdata_d;

    logic mem_pend;
    logic if_pend;

    assign mem_pend   = mem_req & ~mem_served_q;
    assign if_pend    = if_req  & ~if_served_q;
    assign pipe_stall = mem_pend | if_pend;

    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        if_served_d  = if_served_q;
        mem_served_d = mem_served_q;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        ram_en_d     = ram_en_q;
        ram_we_d     = ram_we_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;

        // Pipeline advances: every requester starts a fresh pipeline cycle.
        // With no stall there is no pending request, so no grant can collide.
        if (!pipe_stall) begin
            if_served_d  = 1'b0;
            mem_served_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (mem_pend) begin
                    state_d     = BUSY_MEM;
                    ram_en_d    = 1'b1;
                    ram_we_d    = mem_we;
                    ram_addr_d  = mem_addr;
                    ram_wdata_d = mem_wdata;
                    cnt_d       = CNT_INIT;
                end else if (if_pend) begin
                    state_d    = BUSY_IF;
                    ram_en_d   = 1'b1;
                    ram_we_d   = 1'b0;
                    ram_addr_d = if_addr;
                    cnt_d      = CNT_INIT;
                end
            end
            BUSY_MEM, BUSY_IF: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Completion always sets the flag, even if the request was
                    // dropped meanwhile; a stale flag is cleared at the next
                    // advance and is harmless because it is masked by ~req.
                    if (state_q == BUSY_MEM) begin
                        if (!ram_we_q) mem_rdata_d = ram_rdata;
                        mem_served_d = 1'b1;
                    end else begin
                        if_rdata_d  = ram_rdata;
                        if_served_d = 1'b1;
                    end
                    ram_en_d = 1'b0;
                    ram_we_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            if_served_q  <= 1'b0;
            mem_served_q <= 1'b0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            if_served_q  <= if_served_d;
            mem_served_q <= mem_served_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (pipe_stall && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stall_cnt_q <= 32'd0;
        else      stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for unified_mem_arbiter (MEM_LATENCY=2). A behavioural RAM and a
// shadow model produce expected read data; each issued access is pushed to a
// scoreboard and checked when the RAM enable falls (access completion).
// ---------------------------------------------------------------------------
module tb_unified_mem_arbiter;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [31:0] if_rdata, mem_rdata;
    logic        pipe_stall, ram_en, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    unified_mem_arbiter #(.MEM_LATENCY(L), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .pipe_stall(pipe_stall),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef ARB_PERF_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural RAM: combinational read, write on every enabled write cycle.
    logic [31:0] ram_mem [1024];
    logic [31:0] model   [1024];
    assign ram_rdata = ram_mem[ram_addr[11:2]];
    always @(posedge clk) if (ram_en && ram_we) ram_mem[ram_addr[11:2]] <= ram_wdata;

    typedef struct {
        int          kind;   // 0 = IF read, 1 = MEM load, 2 = MEM store
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;  // expected rdata register after completion
    } sb_t;
    sb_t sb[$];

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_mem = 32'd0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        ram_mem[a[11:2]] = d;
        model[a[11:2]]   = d;
    endtask

    task automatic push_mem(input logic we, input logic [31:0] a, input logic [31:0] d);
        sb_t e;
        e.addr = a;
        e.wdata = d;
        if (we) begin
            e.kind = 2;
            model[a[11:2]] = d;
        end else begin
            e.kind = 1;
            exp_mem = model[a[11:2]];
        end
        e.rdata = exp_mem;
        sb.push_back(e);
    endtask

    task automatic push_if(input logic [31:0] a);
        sb_t e;
        e.kind = 0; e.addr = a; e.wdata = 32'd0; e.rdata = model[a[11:2]];
        sb.push_back(e);
    endtask

    // Completion monitor: checks each access against the scoreboard head.
    int   hi = 0;
    logic prev_en = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            hi = 0;
            prev_en = 1'b0;
        end else begin
            if (ram_en) begin
                hi++;
                if (sb.size() == 0) chk("sb_unexpected_access", 32'd1, 32'd0);
                else begin
                    chk("ram_addr", ram_addr, sb[0].addr);
                    chk("ram_we", {31'd0, ram_we}, {31'd0, sb[0].kind == 2});
                    if (sb[0].kind == 2) chk("ram_wdata", ram_wdata, sb[0].wdata);
                end
            end else if (prev_en) begin
                chk("ram_en_len", hi, L);
                if (sb.size() != 0) begin
                    if (sb[0].kind == 0) chk("if_rdata", if_rdata, sb[0].rdata);
                    else                 chk("mem_rdata", mem_rdata, sb[0].rdata);
                    void'(sb.pop_front());
                end
                hi = 0;
            end
            prev_en = ram_en;
        end
    end

    // Drive one pipeline cycle's requests and count stalled edges until free.
    task automatic run(input logic do_if, input logic [31:0] ia, input logic do_mem,
                       input logic we, input logic [31:0] ma, input logic [31:0] wd,
                       output int n);
        @(negedge clk);
        if (do_mem) push_mem(we, ma, wd);
        if (do_if)  push_if(ia);
        if_req = do_if; if_addr = ia;
        mem_req = do_mem; mem_we = we; mem_addr = ma; mem_wdata = wd;
        #1;
        n = 0;
        while (pipe_stall && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("no_timeout", {31'd0, n < 40}, 32'd1);
        if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        logic [31:0] sc0;
        rst = 1'b0;
        if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        if_addr = '0; mem_addr = '0; mem_wdata = '0;
        sc0 = 32'd0;
        for (int i = 0; i < 1024; i++) poke(i << 2, (i * 32'h0101_0107) ^ 32'hA5A5_5A5A);
        poke(32'h40, 32'h8C22_0004);
        poke(32'h100, 32'h0000_DEAD);

        repeat (3) @(negedge clk);
        chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        chk("rst_stall", {31'd0, pipe_stall}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_stall", {31'd0, pipe_stall}, 32'd0);

        // Only IF: 0x40 -> 0x8C220004
        run(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, n);
        chk("if_stall_len", n, L + 1);

        // Dual request: MEM load 0x100 first, then IF
`ifdef ARB_PERF_CNT_EN
        sc0 = stall_cycles;
`endif
        run(1'b1, 32'h44, 1'b1, 1'b0, 32'h100, 32'h0, n);
        chk("dual_stall_len", n, 2 * (L + 1));
`ifdef ARB_PERF_CNT_EN
        chk("perf_stall_cycles", stall_cycles - sc0, 32'd6);
`endif
        chk("dual_idle_after", {31'd0, pipe_stall}, 32'd0);

        // Store 0x200 <- 0x12345678, mem_rdata must stay 0xDEAD
        run(1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'h1234_5678, n);
        chk("store_stall_len", n, L + 1);
        chk("store_keeps_rdata", mem_rdata, 32'h0000_DEAD);
        run(1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, n);
        chk("load_after_store", mem_rdata, 32'h1234_5678);

        // mem_req dropped one cycle after grant: access completes anyway
        @(negedge clk);
        push_mem(1'b0, 32'h300, 32'h0);
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h300;
        @(negedge clk);
        mem_req = 1'b0;
        repeat (5) @(negedge clk);
        chk("drop_stall", {31'd0, pipe_stall}, 32'd0);
        run(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, n);
        chk("after_drop_if_len", n, L + 1);

        // Random mixes of IF / load / store
        for (int k = 0; k < 12; k++) begin
            logic di, dm, w;
            logic [31:0] ia, ma, wd;
            di = 1'($urandom); dm = 1'($urandom); w = 1'($urandom);
            ia = {20'd0, 10'($urandom), 2'b00};
            ma = {20'd0, 10'($urandom), 2'b00};
            wd = $urandom;
            run(di, ia, dm, w, ma, wd, n);
            chk("rand_stall_len", n, (int'(di) + int'(dm)) * (L + 1));
        end

        // Reset in the middle of a MEM access
        @(negedge clk);
        push_mem(1'b0, 32'h104, 32'h0);
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h104;
        @(posedge clk); #1;
        chk("pre_rst_ram_en", {31'd0, ram_en}, 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst_ram_en", {31'd0, ram_en}, 32'd0);
        chk("midrst_mem_rdata", mem_rdata, 32'd0);
        mem_req = 1'b0;
        #1;
        chk("midrst_stall", {31'd0, pipe_stall}, 32'd0);
        exp_mem = 32'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        run(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, n);
        chk("post_rst_len", n, L + 1);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
